// File: rtl/d_sramlike_bridge.sv
// ============================================================================
// Module      : d_sramlike_bridge
// Description : MEM-stage bridge from an SRAM-style request to the sram-like
//               data bus, stalling the pipeline until the transaction is done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module d_sramlike_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic        flush,
    input  logic        longest_stall,
    output logic        d_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_rdata;
    logic [1:0]  w_wsize;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DATA && data_data_ok) begin
                r_rdata <= data_rdata;
            end
        end
    end

    // An accepted transaction always runs to data_ok; flush only matters
    // before acceptance or once the result is already parked in S_DONE.
    always_comb begin
        w_next_state = r_state;
        data_req     = 1'b0;
        case (r_state)
            S_IDLE: begin
                data_req = data_sram_en & ~flush;
                if (data_req && data_addr_ok) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (data_data_ok) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (flush || !longest_stall) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_wsize = 2'd2;
        case (data_sram_wen)
            4'b1111:                            w_wsize = 2'd2;
            4'b1100, 4'b0011:                   w_wsize = 2'd1;
            4'b1000, 4'b0100, 4'b0010, 4'b0001: w_wsize = 2'd0;
            default:                            w_wsize = 2'd2;
        endcase
    end

    // Reads fetch the aligned word; the formatter picks the bytes out of it.
    assign data_wr         = |data_sram_wen;
    assign data_size       = data_wr ? w_wsize : 2'd2;
    assign data_addr       = data_wr ? data_sram_addr : {data_sram_addr[31:2], 2'b00};
    assign data_wdata      = data_sram_wdata;
    assign data_sram_rdata = r_rdata;
    assign d_stall         = (data_sram_en & ~flush & (r_state != S_DONE))
                           | (r_state == S_DATA);

endmodule

`default_nettype wire

// File: doc/d_sramlike_bridge.md
# d_sramlike_bridge

MEM-stage data-memory handshake bridge. It sits directly downstream of the load/store byte-lane formatter: it takes the formatter's SRAM-style request (enable, byte write-enables, address, write data) and drives it onto the sram-like data bus (req / addr_ok / data_ok). It stalls the pipeline until the transaction completes, then holds the returned read word stable for the formatter's load extraction until the pipeline advances.

## Interface
Parameters: none.

Clock and reset: one clock; reset is synchronous and active-high.

- clk  in  1  core clock; all state changes on its rising edge
- rst  in  1  synchronous reset, active-high
- data_sram_en  in  1  MEM stage holds a load or store
- data_sram_wen  in  4  byte write-enables from the formatter; 4'b0000 means a load
- data_sram_addr  in  32  physical byte address (ALU result)
- data_sram_wdata  in  32  lane-replicated store data
- data_sram_rdata  out  32  registered read word returned to the formatter
- flush  in  1  exception/flush of the MEM-stage instruction
- longest_stall  in  1  OR of all other pipeline stall sources (excludes d_stall)
- d_stall  out  1  data-side stall request to the hazard unit
- data_req  out  1  sram-like request valid
- data_wr  out  1  1 = write, 0 = read
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  request address
- data_wdata  out  32  request write data
- data_addr_ok  in  1  slave accepted the request this cycle
- data_data_ok  in  1  slave completed the transaction this cycle
- data_rdata  in  32  read data, valid when data_data_ok=1

## Operation
States: S_IDLE, S_DATA, S_DONE.

**S_IDLE**
- data_req = data_sram_en & ~flush.
- Request fields are driven combinationally from the inputs. The inputs are stable because d_stall freezes the MEM stage.
- On data_req & data_addr_ok, go to S_DATA.

**S_DATA**
- data_req = 0.
- On data_data_ok:
  - Capture data_rdata into rdata_r. Writes also capture it; the value is unused.
  - Go to S_DONE.
- flush does not cancel an accepted transaction. The bridge still waits for data_ok.

**S_DONE**
- Transaction finished. d_stall = 0.
- If ~longest_stall, go to S_IDLE; the pipeline advances on this same edge.
- Otherwise stay in S_DONE and hold rdata_r.
- flush in S_DONE goes to S_IDLE.

**Outputs**
- d_stall = data_sram_en & ~flush & (state != S_DONE), or (state == S_DATA) regardless of flush.
- data_sram_rdata = rdata_r.

**Request encoding**
- data_wr = |data_sram_wen.
- data_wdata = data_sram_wdata.
- Writes use data_addr = data_sram_addr. data_size is decoded from wen:
  - 1111 gives 2.
  - 1100 or 0011 gives 1.
  - 1000, 0100, 0010 or 0001 gives 0.
  - Any other nonzero pattern gives 2 and is not a legal request.
- Reads use data_size = 2 and data_addr = {data_sram_addr[31:2], 2'b00}. The formatter selects the bytes.

**Reset**
- state = S_IDLE, rdata_r = 0, d_stall = 0, data_req = 0.
- Reset mid-transaction abandons it. The slave shares rst.

## Timing
- At most one outstanding transaction.
- data_req is never asserted in S_DATA or S_DONE.
- Slave contract: data_ok arrives no earlier than the cycle after addr_ok.
- Minimum memory-op occupancy is 3 cycles:
  - Cycle 0: S_IDLE, req and addr_ok.
  - Cycle 1: S_DATA, data_ok.
  - Cycle 2: S_DONE, d_stall=0.
- If addr_ok is delayed, data_req stays high with fields unchanged until acceptance.
- rdata_r is valid from the first S_DONE cycle. It stays constant until the next data_data_ok.
- An instruction with en=0 passes through S_IDLE with d_stall=0 and data_req=0.
- Back-to-back memory ops: the second issues its req in the cycle after S_DONE→S_IDLE, with no idle gap beyond that.

## Test plan
- **Word load, zero wait:** en=1, wen=0, addr=0x8000_0006; addr_ok at cycle 0, data_ok at cycle 1 with rdata=0xDEADBEEF.
  - Required: data_addr=0x8000_0004, size=2, wr=0.
  - d_stall=1 in cycles 0-1 and 0 in cycle 2.
  - data_sram_rdata=0xDEADBEEF in cycle 2.
- **Byte store:** wen=4'b0100, addr=0x1001, wdata=0xABABABAB; addr_ok delayed 3 cycles.
  - Required: req held 4 cycles with addr=0x1001, size=0, wr=1.
  - d_stall stays high until S_DONE.
- **Half store:** wen=4'b0011, addr=0x2002.
  - Required: size=1, addr=0x2002.
- **Held stall:** complete a load, then longest_stall=1 for 5 cycles.
  - Required: state stays S_DONE, d_stall=0, rdata stable, no new req.
  - S_IDLE follows on release.
- **Flush:** flush in S_IDLE gives req=0 and d_stall=0.
  - Flush in S_DATA keeps d_stall=1 until data_ok, then S_DONE, then S_IDLE.
- **Reset:** rst asserted in S_DATA.
  - Required next cycle: S_IDLE, req=0, d_stall=0, data_sram_rdata=0.
